// File: rtl/dmem4_responder.sv
// dmem4_responder: single-port RAM responder for a 4-lane, 16-byte-line data
// interface. A request is latched in IDLE. The four words are then handled one
// per cycle in RUN. CAPT collects the last read word. done pulses in the
// following IDLE cycle.
// Optional build macro: DMEM4_BOUNDS_CHECK_EN. When it is defined, an
// out-of-range or misaligned address is flagged with err, is not written, and
// reads back as zero.
//
// state | meaning
// IDLE  | waiting for req; done/err may pulse here
// RUN   | cnt 0..3 addresses word cnt of the latched line
// CAPT  | last read word returns from RAM into rd_dm3
module dmem4_responder #(
  parameter int LINES = 64,
  parameter int LW    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we_dm,
  input  logic [31:0] addr,
  input  logic [31:0] wd_dm0,
  input  logic [31:0] wd_dm1,
  input  logic [31:0] wd_dm2,
  input  logic [31:0] wd_dm3,
  output logic [31:0] rd_dm0,
  output logic [31:0] rd_dm1,
  output logic [31:0] rd_dm2,
  output logic [31:0] rd_dm3,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, RUN, CAPT} state_e;

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            accept;

  logic [LW-1:0]   line_q;
  logic            we_q;
  logic [31:0]     wd_q [4];
  logic            bad_q, bad_d;

  logic [31:0]     mem [4*LINES];
  logic [LW+1:0]   ram_addr;
  logic            ram_we;
  logic [31:0]     ram_rdata_q;

  logic [31:0]     rd_q [4];
  logic            cap_en;
  logic [1:0]      cap_idx;
  logic            done_q, err_q;

`ifdef DMEM4_BOUNDS_CHECK_EN
  assign bad_d = (addr[31:4] >= 28'(LINES)) || (addr[3:0] != 4'd0);
`else
  // Upper and byte-offset address bits are intentionally dropped (line aliasing).
  logic unused_addr;
  assign unused_addr = ^{addr[31:LW+4], addr[3:0]};
  assign bad_d = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          state_d = RUN;
          cnt_d   = 2'd0;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = CAPT;
      end
      CAPT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the request fields on acceptance only; ignored while busy
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
      we_q   <= 1'b0;
      bad_q  <= 1'b0;
      for (int i = 0; i < 4; i++) wd_q[i] <= '0;
    end else if (accept) begin
      line_q  <= addr[LW+3:4];
      we_q    <= we_dm;
      bad_q   <= bad_d;
      wd_q[0] <= wd_dm0;
      wd_q[1] <= wd_dm1;
      wd_q[2] <= wd_dm2;
      wd_q[3] <= wd_dm3;
    end
  end

  assign ram_addr = {line_q, cnt_q};
  // rst gates the write so that an aborted request stops at once
  assign ram_we   = (state_q == RUN) && we_q && !bad_q && !rst;

  // Single-port synchronous RAM, never reset
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= wd_q[cnt_q];
    ram_rdata_q <= mem[ram_addr];
  end

  // Read data trails the address by one cycle. In CAPT, cnt has wrapped to 0,
  // so cnt-1 selects lane 3 there as well.
  assign cap_en  = !we_q && (((state_q == RUN) && (cnt_q != 2'd0)) || (state_q == CAPT));
  assign cap_idx = cnt_q - 2'd1;

  // Read-lane capture registers; held across writes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rd_q[i] <= '0;
    end else if (cap_en) begin
      rd_q[cap_idx] <= bad_q ? 32'd0 : ram_rdata_q;
    end
  end

  // Completion pulse one cycle after CAPT
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= (state_q == CAPT);
      err_q  <= (state_q == CAPT) && bad_q;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign err    = err_q;
  assign rd_dm0 = rd_q[0];
  assign rd_dm1 = rd_q[1];
  assign rd_dm2 = rd_q[2];
  assign rd_dm3 = rd_q[3];

endmodule

// File: tb/tb_dmem4_responder.sv
module tb_dmem4_responder;
  logic        clk = 1'b0;
  logic        rst, req, we_dm;
  logic [31:0] addr, wd_dm0, wd_dm1, wd_dm2, wd_dm3;
  logic [31:0] rd_dm0, rd_dm1, rd_dm2, rd_dm3;
  logic        busy, done, err;

  int n_cmp  = 0;
  int n_fail = 0;

  dmem4_responder #(.LINES(64), .LW(6)) dut (
    .clk(clk), .rst(rst), .req(req), .we_dm(we_dm), .addr(addr),
    .wd_dm0(wd_dm0), .wd_dm1(wd_dm1), .wd_dm2(wd_dm2), .wd_dm3(wd_dm3),
    .rd_dm0(rd_dm0), .rd_dm1(rd_dm1), .rd_dm2(rd_dm2), .rd_dm3(rd_dm3),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                        input logic [31:0] e2, input logic [31:0] e3);
    chk({tag, ".rd0"}, rd_dm0, e0);
    chk({tag, ".rd1"}, rd_dm1, e1);
    chk({tag, ".rd2"}, rd_dm2, e2);
    chk({tag, ".rd3"}, rd_dm3, e3);
  endtask

  // Issue one request in the current cycle; return in the done cycle.
  task automatic do_req(input logic we, input logic [31:0] a,
                        input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3,
                        output int lat, output logic err_d, output logic busy_ok);
    req = 1'b1; we_dm = we; addr = a;
    wd_dm0 = w0; wd_dm1 = w1; wd_dm2 = w2; wd_dm3 = w3;
    tick();
    req = 1'b0;
    lat = 0; err_d = 1'b0; busy_ok = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      if (done) begin
        lat = k; err_d = err;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
    end
  endtask

  initial begin : stim
    int   lat;
    logic e, bok;
    int   ndone;

    rst = 1'b1; req = 1'b0; we_dm = 1'b0; addr = '0;
    wd_dm0 = '0; wd_dm1 = '0; wd_dm2 = '0; wd_dm3 = '0;

    // 1 Reset
    tick(); tick();
    rst = 1'b0;
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.done", {31'd0, done}, 32'd0);
    chk("reset.err",  {31'd0, err},  32'd0);
    chk_rd("reset", 32'd0, 32'd0, 32'd0, 32'd0);
    tick();

    // 2 Write then read line 0x40
    do_req(1'b1, 32'h40, 32'h11, 32'h22, 32'h33, 32'h44, lat, e, bok);
    chk("wr40.lat", lat, 6);
    chk("wr40.busy", {31'd0, bok}, 32'd1);
    chk("wr40.err", {31'd0, e}, 32'd0);
    chk_rd("wr40.unchanged", 32'd0, 32'd0, 32'd0, 32'd0);
    tick();
    do_req(1'b0, 32'h40, 32'h0, 32'h0, 32'h0, 32'h0, lat, e, bok);
    chk("rd40.lat", lat, 6);
    chk("rd40.busy", {31'd0, bok}, 32'd1);
    chk_rd("rd40", 32'h11, 32'h22, 32'h33, 32'h44);
    tick();

    // 3 Back-to-back: write 0x80, then read 0x40, then read 0x80 in the done cycle
    do_req(1'b1, 32'h80, 32'hA0, 32'hA1, 32'hA2, 32'hA3, lat, e, bok);
    chk("wr80.lat", lat, 6);
    chk_rd("wr80.unchanged", 32'h11, 32'h22, 32'h33, 32'h44);
    do_req(1'b0, 32'h40, 32'h0, 32'h0, 32'h0, 32'h0, lat, e, bok);
    chk("b2b.rd40.lat", lat, 6);
    do_req(1'b0, 32'h80, 32'h0, 32'h0, 32'h0, 32'h0, lat, e, bok);
    chk("b2b.rd80.lat", lat, 6);
    chk_rd("b2b.rd80", 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    tick();

    // 4 Req while busy: read 0x40, at T+2 pulse a write to 0x80
    req = 1'b1; we_dm = 1'b0; addr = 32'h40;
    tick();
    req = 1'b0;
    tick();
    req = 1'b1; we_dm = 1'b1; addr = 32'h80;
    wd_dm0 = 32'hDEAD; wd_dm1 = 32'hDEAD; wd_dm2 = 32'hDEAD; wd_dm3 = 32'hDEAD;
    tick();
    req = 1'b0; we_dm = 1'b0; addr = '0;
    ndone = 0;
    for (int k = 3; k <= 14; k++) begin
      if (done) ndone++;
      tick();
    end
    chk("busyreq.ndone", ndone, 1);
    chk_rd("busyreq.rd40", 32'h11, 32'h22, 32'h33, 32'h44);
    do_req(1'b0, 32'h80, 32'h0, 32'h0, 32'h0, 32'h0, lat, e, bok);
    chk_rd("busyreq.line80", 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    tick();

    // 5 Reset mid-write
    do_req(1'b1, 32'h40, 32'd1, 32'd2, 32'd3, 32'd4, lat, e, bok);
    tick();
    req = 1'b1; we_dm = 1'b1; addr = 32'h40;
    wd_dm0 = 32'd9; wd_dm1 = 32'd9; wd_dm2 = 32'd9; wd_dm3 = 32'd9;
    tick();            // T+1
    req = 1'b0;
    tick();            // T+2
    tick();            // T+3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst.busy", {31'd0, busy}, 32'd0);
    chk("midrst.done", {31'd0, done}, 32'd0);
    chk_rd("midrst", 32'd0, 32'd0, 32'd0, 32'd0);
    tick();
    do_req(1'b0, 32'h40, 32'h0, 32'h0, 32'h0, 32'h0, lat, e, bok);
    chk("midrst.rd.lat", lat, 6);
    chk_rd("midrst.rd40", 32'd9, 32'd9, 32'd3, 32'd4);
    tick();

    // 6 Bounds: addr 0x400 against line 0
    do_req(1'b1, 32'h0, 32'h70, 32'h71, 32'h72, 32'h73, lat, e, bok);
    tick();
    do_req(1'b1, 32'h400, 32'h55, 32'h56, 32'h57, 32'h58, lat, e, bok);
    chk("oob.wr.lat", lat, 6);
    chk("oob.wr.busy", {31'd0, bok}, 32'd1);
`ifdef DMEM4_BOUNDS_CHECK_EN
    chk("oob.wr.err", {31'd0, e}, 32'd1);
`else
    chk("oob.wr.err", {31'd0, e}, 32'd0);
`endif
    tick();
    do_req(1'b0, 32'h400, 32'h0, 32'h0, 32'h0, 32'h0, lat, e, bok);
    chk("oob.rd.lat", lat, 6);
`ifdef DMEM4_BOUNDS_CHECK_EN
    chk("oob.rd.err", {31'd0, e}, 32'd1);
    chk_rd("oob.rd", 32'd0, 32'd0, 32'd0, 32'd0);
`else
    chk("oob.rd.err", {31'd0, e}, 32'd0);
    chk_rd("oob.rd", 32'h55, 32'h56, 32'h57, 32'h58);
`endif
    tick();
    do_req(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, lat, e, bok);
    chk("line0.err", {31'd0, e}, 32'd0);
`ifdef DMEM4_BOUNDS_CHECK_EN
    chk_rd("line0", 32'h70, 32'h71, 32'h72, 32'h73);
`else
    chk_rd("line0", 32'h55, 32'h56, 32'h57, 32'h58);
`endif
    tick();
    chk("idle.done", {31'd0, done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
